// File: rtl/dma_pcie_mi_ram_pkg.sv
// Shared constants, types and the lane-parity helper for the MI RAM responder.
package dma_pcie_mi_ram_pkg;

   localparam int DEPTH        = 4096;
   localparam int ADR_W        = $clog2(DEPTH);
   localparam int DAT_W        = 128;
   localparam int PAR_W        = 8;
   localparam int LANE_W       = 16;
   localparam int NUM_LANES    = DAT_W / LANE_W;
   localparam int DW_W         = 32;
   localparam int NUM_DW       = DAT_W / DW_W;
   localparam int LANES_PER_DW = DW_W / LANE_W;
   localparam int SAT_CNT_W    = 16;
   localparam int RD_STAGES    = 2;

   typedef enum logic {INIT, RUN} ram_state_e;

   typedef struct packed {
      logic [NUM_DW-1:0] wen;
      logic [ADR_W-1:0]  adr;
      logic [DAT_W-1:0]  dat;
      logic [PAR_W-1:0]  par;
   } wr_req_t;

   typedef struct packed {
      logic [DAT_W-1:0] dat;
      logic [PAR_W-1:0] par;
      logic             sbe;
      logic             dbe;
   } rd_rsp_t;

   // Even parity of each 16b lane.
   function automatic logic [PAR_W-1:0] lane_par(input logic [DAT_W-1:0] dat);
      logic [PAR_W-1:0] p;
      for (int j = 0; j < NUM_LANES; j++) p[j] = ^dat[j*LANE_W +: LANE_W];
      return p;
   endfunction

endpackage

// File: rtl/dma_pcie_mi_ram_par_chk.sv
// Combinational lane parity checker: masked mismatch vector plus single/multi-lane flags.
module dma_pcie_mi_ram_par_chk
   import dma_pcie_mi_ram_pkg::*;
(
   input  logic [DAT_W-1:0] dat,
   input  logic [PAR_W-1:0] par,
   input  logic [PAR_W-1:0] lane_msk,
   output logic [PAR_W-1:0] mis,
   output logic             sbe,
   output logic             dbe
);

   logic [PAR_W-1:0] mis_rest;

   assign mis      = (par ^ lane_par(dat)) & lane_msk;
   // Clearing the lowest set bit leaves something only if two or more lanes failed.
   assign mis_rest = mis & (mis - PAR_W'(1));
   assign sbe      = (mis != '0) && (mis_rest == '0);
   assign dbe      = (mis_rest != '0);

endmodule

// File: rtl/dma_pcie_mi_ram_slv.sv
// MI RAM responder: 4096x(128b+8b parity), self zero-init, 2-cycle reads, parity checks.
// Optional read-path error injection when DMA_PCIE_MI_RAM_ERR_INJ_EN is defined.
module dma_pcie_mi_ram_slv
   import dma_pcie_mi_ram_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADR_W-1:0]     mi_wadr,
   input  logic [NUM_DW-1:0]    mi_wen,
   input  logic [PAR_W-1:0]     mi_wpar,
   input  logic [DAT_W-1:0]     mi_wdat,
   input  logic                 mi_ren,
   input  logic [ADR_W-1:0]     mi_radr,
`ifdef DMA_PCIE_MI_RAM_ERR_INJ_EN
   input  logic [1:0]           err_inj,
`endif
   output logic [PAR_W-1:0]     mi_rpar,
   output logic [DAT_W-1:0]     mi_rdat,
   output logic                 mi_rsbe,
   output logic                 mi_rdbe,
   output logic                 init_done,
   output logic                 wr_par_err,
   output logic [SAT_CNT_W-1:0] sbe_cnt,
   output logic [SAT_CNT_W-1:0] dbe_cnt
);

   localparam int SLC_W = DW_W + LANES_PER_DW;

   ram_state_e       state_q;
   logic [ADR_W-1:0] init_adr_q;
   logic             init_done_q;
   logic             run;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= INIT;
         init_adr_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               init_adr_q <= init_adr_q + ADR_W'(1);
               if (init_adr_q == ADR_W'(DEPTH - 1)) begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            RUN:     state_q <= RUN;
            default: state_q <= INIT;
         endcase
      end
   end

   assign run = (state_q == RUN);

   // Write port is owned by the zero sweep until RUN.
   wr_req_t wr_req;
   logic    rd_en;

   always_comb begin
      wr_req.wen = {NUM_DW{1'b1}};
      wr_req.adr = init_adr_q;
      wr_req.dat = '0;
      wr_req.par = '0;
      if (run) begin
         wr_req.wen = mi_wen;
         wr_req.adr = mi_wadr;
         wr_req.dat = mi_wdat;
         wr_req.par = mi_wpar;
      end
   end

   assign rd_en = run & mi_ren;

   logic [NUM_DW-1:0][DW_W-1:0]         s1_dw;
   logic [NUM_DW-1:0][LANES_PER_DW-1:0] s1_dpar;

   // One RAM per dword gives per-dword write enables; read-first on collision.
   for (genvar d = 0; d < NUM_DW; d++) begin : g_dw
      logic [SLC_W-1:0] mem [DEPTH];
      logic [SLC_W-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (wr_req.wen[d])
            mem[wr_req.adr] <= {wr_req.par[d*LANES_PER_DW +: LANES_PER_DW],
                                wr_req.dat[d*DW_W +: DW_W]};
         if (rd_en) rd_q <= mem[mi_radr];
      end

      assign s1_dw[d]   = rd_q[DW_W-1:0];
      assign s1_dpar[d] = rd_q[SLC_W-1:DW_W];
   end

   logic [DAT_W-1:0] s1_dat;
   logic [PAR_W-1:0] s1_par;
   logic [DAT_W-1:0] chk_dat;

   assign s1_dat = s1_dw;
   assign s1_par = s1_dpar;

`ifdef DMA_PCIE_MI_RAM_ERR_INJ_EN
   logic [1:0] inj_q;
   logic [1:0] inj_d;

   always_comb begin
      inj_d = inj_q;
      if (rd_en) inj_d = err_inj;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) inj_q <= '0;
      else        inj_q <= inj_d;
   end

   always_comb begin
      chk_dat = s1_dat;
      if (inj_q != 2'b00) chk_dat[0]  = ~s1_dat[0];
      if (inj_q[1])       chk_dat[16] = ~s1_dat[16];
   end
`else
   assign chk_dat = s1_dat;
`endif

   logic [PAR_W-1:0] unused_rd_mis;
   logic             rd_sbe, rd_dbe;

   dma_pcie_mi_ram_par_chk u_rd_chk (
      .dat      (chk_dat),
      .par      (s1_par),
      .lane_msk ({PAR_W{1'b1}}),
      .mis      (unused_rd_mis),
      .sbe      (rd_sbe),
      .dbe      (rd_dbe)
   );

   logic [PAR_W-1:0] wr_lane_msk;
   logic [PAR_W-1:0] unused_wr_mis;
   logic             wr_sbe, wr_dbe;

   for (genvar j = 0; j < NUM_LANES; j++) begin : g_wmsk
      assign wr_lane_msk[j] = mi_wen[j / LANES_PER_DW];
   end

   dma_pcie_mi_ram_par_chk u_wr_chk (
      .dat      (mi_wdat),
      .par      (mi_wpar),
      .lane_msk (wr_lane_msk),
      .mis      (unused_wr_mis),
      .sbe      (wr_sbe),
      .dbe      (wr_dbe)
   );

   logic [RD_STAGES:1]   vld_pipe_q, vld_pipe_d;
   rd_rsp_t              rsp_q, rsp_d;
   logic                 wr_par_err_q, wr_par_err_d;
   logic [SAT_CNT_W-1:0] sbe_cnt_q, sbe_cnt_d;
   logic [SAT_CNT_W-1:0] dbe_cnt_q, dbe_cnt_d;

   always_comb begin
      vld_pipe_d   = {vld_pipe_q[RD_STAGES-1:1], rd_en};
      rsp_d        = rsp_q;
      wr_par_err_d = run && (wr_sbe || wr_dbe);
      sbe_cnt_d    = sbe_cnt_q;
      dbe_cnt_d    = dbe_cnt_q;
      if (vld_pipe_q[1]) begin
         rsp_d.dat = chk_dat;
         rsp_d.par = s1_par;
         rsp_d.sbe = rd_sbe;
         rsp_d.dbe = rd_dbe;
      end
      // Counters count from the registered flags to stay off the check path.
      if (vld_pipe_q[RD_STAGES] && rsp_q.sbe && (sbe_cnt_q != {SAT_CNT_W{1'b1}}))
         sbe_cnt_d = sbe_cnt_q + SAT_CNT_W'(1);
      if (vld_pipe_q[RD_STAGES] && rsp_q.dbe && (dbe_cnt_q != {SAT_CNT_W{1'b1}}))
         dbe_cnt_d = dbe_cnt_q + SAT_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe_q   <= '0;
         rsp_q        <= '0;
         wr_par_err_q <= 1'b0;
         sbe_cnt_q    <= '0;
         dbe_cnt_q    <= '0;
      end else begin
         vld_pipe_q   <= vld_pipe_d;
         rsp_q        <= rsp_d;
         wr_par_err_q <= wr_par_err_d;
         sbe_cnt_q    <= sbe_cnt_d;
         dbe_cnt_q    <= dbe_cnt_d;
      end
   end

   assign mi_rdat    = rsp_q.dat;
   assign mi_rpar    = rsp_q.par;
   assign mi_rsbe    = rsp_q.sbe;
   assign mi_rdbe    = rsp_q.dbe;
   assign init_done  = init_done_q;
   assign wr_par_err = wr_par_err_q;
   assign sbe_cnt    = sbe_cnt_q;
   assign dbe_cnt    = dbe_cnt_q;

endmodule

// File: tb/tb_dma_pcie_mi_ram_slv.sv
// Directed bench for dma_pcie_mi_ram_slv: shadow-memory scoreboard on read results.
module tb_dma_pcie_mi_ram_slv;

   logic         clk;
   logic         rst_n;
   logic [11:0]  mi_wadr;
   logic [3:0]   mi_wen;
   logic [7:0]   mi_wpar;
   logic [127:0] mi_wdat;
   logic         mi_ren;
   logic [11:0]  mi_radr;
   logic [1:0]   err_inj;
   logic [7:0]   mi_rpar;
   logic [127:0] mi_rdat;
   logic         mi_rsbe, mi_rdbe, init_done, wr_par_err;
   logic [15:0]  sbe_cnt, dbe_cnt;

   dma_pcie_mi_ram_slv dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mi_wadr    (mi_wadr),
      .mi_wen     (mi_wen),
      .mi_wpar    (mi_wpar),
      .mi_wdat    (mi_wdat),
      .mi_ren     (mi_ren),
      .mi_radr    (mi_radr),
`ifdef DMA_PCIE_MI_RAM_ERR_INJ_EN
      .err_inj    (err_inj),
`endif
      .mi_rpar    (mi_rpar),
      .mi_rdat    (mi_rdat),
      .mi_rsbe    (mi_rsbe),
      .mi_rdbe    (mi_rdbe),
      .init_done  (init_done),
      .wr_par_err (wr_par_err),
      .sbe_cnt    (sbe_cnt),
      .dbe_cnt    (dbe_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] dat;
      logic [7:0]   par;
      logic         sbe;
      logic         dbe;
      string        tag;
   } exp_t;

   exp_t         sb[$];
   logic [135:0] mdl [4096];
   int           checks = 0;
   int           fails  = 0;
   logic         trk = 1'b0, p1 = 1'b0, p2 = 1'b0;

   function automatic logic [7:0] ref_par(input logic [127:0] d);
      logic [7:0] p;
      for (int j = 0; j < 8; j++) p[j] = ^d[16*j +: 16];
      return p;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock with the given stimulus; read expectations come from the model before the write lands.
   task automatic step(input logic [3:0] wen, input logic [11:0] wadr, input logic [127:0] wdat,
                       input logic [7:0] wpar, input logic ren, input logic [11:0] radr,
                       input logic [1:0] inj, input string tag);
      exp_t         e;
      logic [7:0]   mis;
      logic [127:0] flip;
      mi_wen = wen; mi_wadr = wadr; mi_wdat = wdat; mi_wpar = wpar;
      mi_ren = ren; mi_radr = radr; err_inj = inj; trk = ren;
      if (ren) begin
         flip = '0;
         if (inj != 2'b00) flip[0] = 1'b1;
         if (inj[1])       flip[16] = 1'b1;
         e.dat = mdl[radr][127:0] ^ flip;
         e.par = mdl[radr][135:128];
         mis   = e.par ^ ref_par(e.dat);
         e.sbe = ($countones(mis) == 1);
         e.dbe = ($countones(mis) >= 2);
         e.tag = tag;
         sb.push_back(e);
      end
      for (int i = 0; i < 4; i++) begin
         if (wen[i]) begin
            mdl[wadr][32*i +: 32]     = wdat[32*i +: 32];
            mdl[wadr][128+2*i +: 2]   = wpar[2*i +: 2];
         end
      end
      @(posedge clk); #1;
      mi_wen = '0; mi_ren = 1'b0; err_inj = '0; trk = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(4'h0, 12'h0, '0, 8'h0, 1'b0, 12'h0, 2'b00, "idle");
   endtask

   always @(posedge clk) begin
      p1 <= trk;
      p2 <= p1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (p2) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 128'h1, 128'h0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_dat"}, mi_rdat, e.dat);
            chk({e.tag, "_par"}, {120'h0, mi_rpar}, {120'h0, e.par});
            chk({e.tag, "_sbe"}, {127'h0, mi_rsbe}, {127'h0, e.sbe});
            chk({e.tag, "_dbe"}, {127'h0, mi_rdbe}, {127'h0, e.dbe});
         end
      end
   end

   logic [127:0] d_full, d_part, d_err;
   int           bad;

   initial begin
      rst_n = 1'b0; mi_wen = '0; mi_wadr = '0; mi_wdat = '0; mi_wpar = '0;
      mi_ren = 1'b0; mi_radr = '0; err_inj = '0;
      for (int a = 0; a < 4096; a++) mdl[a] = '0;

      repeat (3) @(posedge clk); #1;
      chk("rst_rdat", mi_rdat, 0);
      chk("rst_rpar", {120'h0, mi_rpar}, 0);
      chk("rst_rsbe_rdbe", {126'h0, mi_rsbe, mi_rdbe}, 0);
      chk("rst_init_done", {127'h0, init_done}, 0);
      chk("rst_wpe", {127'h0, wr_par_err}, 0);
      chk("rst_cnts", {96'h0, sbe_cnt, dbe_cnt}, 0);

      // Partial sweep, reset mid-INIT, then a full sweep with reads and writes hammering the port.
      rst_n = 1'b1; mi_ren = 1'b1;
      mi_wen = 4'hF; mi_wadr = 12'h200; mi_wdat = '1; mi_wpar = 8'h0;
      repeat (1000) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 1; k <= 4096; k++) begin
         @(posedge clk); #1;
         if (k < 4096 && init_done !== 1'b0) bad++;
         if (mi_rdat !== '0 || mi_rsbe !== 1'b0 || mi_rdbe !== 1'b0) bad++;
         mi_radr = 12'($urandom);
      end
      chk("init_done_rise", {127'h0, init_done}, 1);
      chk("init_phase_clean", bad, 0);
      mi_wen = '0; mi_ren = 1'b0;

      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h200, 2'b00, "rd_init_ign");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'hFFF, 2'b00, "rd_top");
      idle(2);

      d_full = 128'h0123456789ABCDEF0123456789ABCDEF;
      step(4'hF, 12'h123, d_full, ref_par(d_full), 1'b0, 12'h0, 2'b00, "wr_full");
      chk("wpe_good", {127'h0, wr_par_err}, 0);
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b00, "rd_full");
      chk("lat_not_early", mi_rdat, 0);
      idle(2);

      d_part = {32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h33333333};
      step(4'b0010, 12'h123, d_part, ref_par(d_part), 1'b0, 12'h0, 2'b00, "wr_part");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b00, "rd_part");

      step(4'hF, 12'h010, '1, ref_par('1), 1'b1, 12'h010, 2'b00, "rd_coll_old");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h010, 2'b00, "rd_coll_new");

      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b00, "b2b_0");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h200, 2'b00, "b2b_1");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h010, 2'b00, "b2b_2");
      idle(3);
      chk("sb_drained_1", sb.size(), 0);
      chk("rdat_hold", mi_rdat, '1);

      d_err = 128'hA5A5_1234_5A5A_8765_0F0F_F0F0_C3C3_3C3C;
      step(4'hF, 12'h300, d_err, ref_par(d_err) ^ 8'h08, 1'b0, 12'h0, 2'b00, "wr_bad1");
      chk("wpe_pulse", {127'h0, wr_par_err}, 1);
      idle(1);
      chk("wpe_clear", {127'h0, wr_par_err}, 0);
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h300, 2'b00, "rd_sbe");
      idle(4);
      chk("sbe_cnt_1", {112'h0, sbe_cnt}, 1);
      chk("dbe_cnt_0", {112'h0, dbe_cnt}, 0);

      step(4'hF, 12'h301, d_err, ref_par(d_err) ^ 8'h22, 1'b0, 12'h0, 2'b00, "wr_bad2");
      chk("wpe_pulse2", {127'h0, wr_par_err}, 1);
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h301, 2'b00, "rd_dbe");
      idle(4);
      chk("dbe_cnt_1", {112'h0, dbe_cnt}, 1);
      chk("sbe_cnt_still1", {112'h0, sbe_cnt}, 1);

      step(4'b0001, 12'h302, d_err, ref_par(d_err) ^ 8'h10, 1'b0, 12'h0, 2'b00, "wr_msk_bad");
      chk("wpe_masked_lane", {127'h0, wr_par_err}, 0);
      step(4'b0001, 12'h302, d_err, ref_par(d_err) ^ 8'h02, 1'b0, 12'h0, 2'b00, "wr_en_bad");
      chk("wpe_enabled_lane", {127'h0, wr_par_err}, 1);
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h302, 2'b00, "rd_mixed");

      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h300, 2'b00, "rd_sbe_b0");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h300, 2'b00, "rd_sbe_b1");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h300, 2'b00, "rd_sbe_b2");
      idle(4);
      chk("sbe_cnt_5", {112'h0, sbe_cnt}, 5);

`ifdef DMA_PCIE_MI_RAM_ERR_INJ_EN
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b10, "rd_inj_dbe");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b00, "rd_inj_clean");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b01, "rd_inj_sbe");
      step(4'h0, 12'h0, '0, 8'h0, 1'b1, 12'h123, 2'b11, "rd_inj_11");
`endif

      idle(4);
      chk("sb_drained_end", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
